rdw_stage: RTL and testbench

- Read-data-wait pipeline stage directly downstream of the memory-access stage and upstream of write-back.
- Collects the sram-like data_ok/rdata response for loads and stores whose request was accepted upstream.
- Aligns and extends load data, selects the final register-write result, and drops responses that belong to flushed instructions.
- Forwards exception info and a flush indication for older-instruction kill.

---
 rtl/rdw_stage.sv | 210 +++++++++++++++++++++
 tb/tb_rdw_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rdw_stage.sv
// rdw_stage: read-data-wait pipeline stage between memory access and write-back.
//
// Collects the sram-like data_ok/rdata response owed for a load or store whose
// request was accepted upstream. It aligns and extends load data, selects the
// final register-write result, and forwards exception info to write-back.
// Responses that belong to flushed instructions are counted in cancel_cnt_q
// and dropped when they arrive.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           handshake with the memory-access stage
//   out_valid / out_ready         handshake with write-back (out_valid registered)
//   pipe_flush, wb_flush          flush commit / flushing instruction in write-back
//   PC, mem_op, alu_result,       instruction payload from upstream
//   side_result, res_from_side,
//   res_from_mem, gr_we, dest
//   req_issued, early_data_valid, response bookkeeping from upstream
//   early_data
//   has_exception, exc_info       exception payload
//   data_ok, rdata                sram-like response channel
//   resp_pending                  next data_ok is not owed to the upstream stage
//   this_flush                    this stage holds a flushing instruction
//   result_bypass                 combinational forwarding value
//   PC_out .. exc_info_out        registered payload to write-back
module rdw_stage #(
  parameter int          CANCEL_W = 2,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        pipe_flush,
  input  logic        wb_flush,
  input  logic [31:0] PC,
  input  logic [7:0]  mem_op,
  input  logic [31:0] alu_result,
  input  logic [31:0] side_result,
  input  logic        res_from_side,
  input  logic        res_from_mem,
  input  logic        gr_we,
  input  logic [4:0]  dest,
  input  logic        req_issued,
  input  logic        early_data_valid,
  input  logic [31:0] early_data,
  input  logic        has_exception,
  input  logic [46:0] exc_info,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        resp_pending,
  output logic        this_flush,
  output logic [31:0] result_bypass,
  output logic [31:0] PC_out,
  output logic [31:0] result_out,
  output logic        gr_we_out,
  output logic [4:0]  dest_out,
  output logic        has_exception_out,
  output logic [46:0] exc_info_out
);

  localparam logic [CANCEL_W-1:0] CNT_ONE  = 1;
  localparam logic [CANCEL_W-1:0] CNT_MAX  = '1;
  localparam logic [CANCEL_W-1:0] CNT_ZERO = '0;

  logic                held_valid_q, held_valid_d;
  logic [31:0]         held_data_q, held_data_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         pc_q, result_q;
  logic                gr_we_q, has_exc_q;
  logic [4:0]          dest_q;
  logic [46:0]         exc_info_q;

  logic        need_resp_s, own_ok_s, ready_go_s, fire_s, cnt_busy_s;
  logic        cancel_inc_s, cancel_dec_s;
  logic [31:0] src_data_s, load_ext_s, result_s;
  logic [7:0]  ld_byte_s;
  logic [15:0] ld_half_s;

  assign cnt_busy_s   = (cancel_cnt_q != CNT_ZERO);
  assign need_resp_s  = in_valid && req_issued && !has_exception;
  assign this_flush   = in_valid && (has_exception || wb_flush);
  // A response is ours only when no orphaned response is still outstanding.
  assign own_ok_s     = data_ok && !cnt_busy_s && need_resp_s && !held_valid_q && !early_data_valid;
  assign ready_go_s   = !in_valid || this_flush || !need_resp_s || early_data_valid
                        || held_valid_q || own_ok_s;
  assign fire_s       = in_valid && ready_go_s && out_ready;
  assign in_ready     = !rst && (!in_valid || (ready_go_s && out_ready));
  assign resp_pending = (need_resp_s && !early_data_valid && !held_valid_q) || cnt_busy_s;

  // The killed instruction's response is still in flight only if nothing has captured it yet.
  assign cancel_inc_s = pipe_flush && need_resp_s && !held_valid_q && !early_data_valid && !data_ok;
  assign cancel_dec_s = data_ok && cnt_busy_s;

  // Load data source selection and alignment/extension.
  always_comb begin
    if (early_data_valid) begin
      src_data_s = early_data;
    end else if (held_valid_q) begin
      src_data_s = held_data_q;
    end else begin
      src_data_s = rdata;
    end
    case (alu_result[1:0])
      2'd0:    ld_byte_s = src_data_s[7:0];
      2'd1:    ld_byte_s = src_data_s[15:8];
      2'd2:    ld_byte_s = src_data_s[23:16];
      2'd3:    ld_byte_s = src_data_s[31:24];
      default: ld_byte_s = src_data_s[7:0];
    endcase
    ld_half_s = alu_result[1] ? src_data_s[31:16] : src_data_s[15:0];
    if (mem_op[0]) begin
      load_ext_s = {{24{ld_byte_s[7]}}, ld_byte_s};
    end else if (mem_op[3]) begin
      load_ext_s = {24'h000000, ld_byte_s};
    end else if (mem_op[1]) begin
      load_ext_s = {{16{ld_half_s[15]}}, ld_half_s};
    end else if (mem_op[4]) begin
      load_ext_s = {16'h0000, ld_half_s};
    end else begin
      load_ext_s = src_data_s;
    end
    if (res_from_mem) begin
      result_s = load_ext_s;
    end else if (res_from_side) begin
      result_s = side_result;
    end else begin
      result_s = alu_result;
    end
  end

  assign result_bypass = result_s;

  // Next state of the orphan counter, holding register and output valid.
  always_comb begin
    cancel_cnt_d = cancel_cnt_q;
    held_valid_d = held_valid_q;
    held_data_d  = held_data_q;
    out_valid_d  = out_valid_q;
    if (cancel_inc_s && !cancel_dec_s) begin
      if (cancel_cnt_q != CNT_MAX) begin
        cancel_cnt_d = cancel_cnt_q + CNT_ONE;
      end else begin
        cancel_cnt_d = cancel_cnt_q;
      end
    end else if (cancel_dec_s && !cancel_inc_s) begin
      cancel_cnt_d = cancel_cnt_q - CNT_ONE;
    end else begin
      cancel_cnt_d = cancel_cnt_q;
    end
    if (pipe_flush || fire_s) begin
      held_valid_d = 1'b0;
    end else if (own_ok_s) begin
      held_valid_d = 1'b1;
      held_data_d  = rdata;
    end else begin
      held_valid_d = held_valid_q;
    end
    if (out_ready) begin
      out_valid_d = in_valid && ready_go_s && !pipe_flush;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cancel_cnt_q <= CNT_ZERO;
      held_valid_q <= 1'b0;
      held_data_q  <= 32'h00000000;
      out_valid_q  <= 1'b0;
    end else begin
      cancel_cnt_q <= cancel_cnt_d;
      held_valid_q <= held_valid_d;
      held_data_q  <= held_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Payload registers toward write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      result_q   <= 32'h00000000;
      gr_we_q    <= 1'b0;
      dest_q     <= 5'd0;
      has_exc_q  <= 1'b0;
      exc_info_q <= 47'h0;
    end else if (fire_s) begin
      pc_q       <= PC;
      result_q   <= result_s;
      gr_we_q    <= gr_we;
      dest_q     <= dest;
      has_exc_q  <= has_exception;
      exc_info_q <= exc_info;
    end
  end

  assign out_valid         = out_valid_q;
  assign PC_out            = pc_q;
  assign result_out        = result_q;
  assign gr_we_out         = gr_we_q;
  assign dest_out          = dest_q;
  assign has_exception_out = has_exc_q;
  assign exc_info_out      = exc_info_q;

endmodule

// File: tb/tb_rdw_stage.sv
module tb_rdw_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, pipe_flush, wb_flush;
  logic [31:0] PC, alu_result, side_result, early_data, rdata, result_bypass, PC_out, result_out;
  logic [7:0]  mem_op;
  logic        res_from_side, res_from_mem, gr_we, req_issued, early_data_valid;
  logic        has_exception, data_ok, resp_pending, this_flush, gr_we_out, has_exception_out;
  logic [4:0]  dest, dest_out;
  logic [46:0] exc_info, exc_info_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rdw_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .pipe_flush(pipe_flush),
    .wb_flush(wb_flush), .PC(PC), .mem_op(mem_op), .alu_result(alu_result),
    .side_result(side_result), .res_from_side(res_from_side),
    .res_from_mem(res_from_mem), .gr_we(gr_we), .dest(dest),
    .req_issued(req_issued), .early_data_valid(early_data_valid),
    .early_data(early_data), .has_exception(has_exception), .exc_info(exc_info),
    .data_ok(data_ok), .rdata(rdata), .resp_pending(resp_pending),
    .this_flush(this_flush), .result_bypass(result_bypass), .PC_out(PC_out),
    .result_out(result_out), .gr_we_out(gr_we_out), .dest_out(dest_out),
    .has_exception_out(has_exception_out), .exc_info_out(exc_info_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_ready = 1'b1; pipe_flush = 1'b0; wb_flush = 1'b0;
    PC = 32'h0; mem_op = 8'h00; alu_result = 32'h0; side_result = 32'h0;
    res_from_side = 1'b0; res_from_mem = 1'b0; gr_we = 1'b0; dest = 5'd0;
    req_issued = 1'b0; early_data_valid = 1'b0; early_data = 32'h0;
    has_exception = 1'b0; exc_info = 47'h0; data_ok = 1'b0; rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%h exp=0", out_valid); end
    checks++; if (PC_out !== 32'h1c000000) begin errors++; $display("FAIL reset_pc got=%h exp=1c000000", PC_out); end
    checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%h exp=0", in_ready); end
    checks++; if (resp_pending !== 1'b0) begin errors++; $display("FAIL reset_resp_pending got=%h exp=0", resp_pending); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    in_valid = 1'b1; PC = 32'h1c000010; mem_op = 8'h01; alu_result = 32'h00001003;
    res_from_mem = 1'b1; gr_we = 1'b1; dest = 5'd5; req_issued = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ldb_wait1 got=%h exp=0", in_ready); end
    checks++; if (resp_pending !== 1'b1) begin errors++; $display("FAIL ldb_pending got=%h exp=1", resp_pending); end
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ldb_wait2 got=%h exp=0", in_ready); end
    tick();
    data_ok = 1'b1; rdata = 32'h80FF1234;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ldb_ready got=%h exp=1", in_ready); end
    checks++; if (result_bypass !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb_bypass got=%h exp=ffffff80", result_bypass); end
    tick();
    checks++; if (result_out !== 32'hFFFFFF80) begin errors++; $display("FAIL ldb_result got=%h exp=ffffff80", result_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ldb_out_valid got=%h exp=1", out_valid); end
    checks++; if (PC_out !== 32'h1c000010) begin errors++; $display("FAIL ldb_pc got=%h exp=1c000010", PC_out); end
    checks++; if (dest_out !== 5'd5) begin errors++; $display("FAIL ldb_dest got=%h exp=05", dest_out); end
    idle();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldb_bubble got=%h exp=0", out_valid); end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; PC = 32'h1c000020; mem_op = 8'h10; alu_result = 32'h00002002;
    res_from_mem = 1'b1; gr_we = 1'b1; dest = 5'd7; req_issued = 1'b1;
    out_ready = 1'b0; data_ok = 1'b1; rdata = 32'h80FF1234;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%h exp=0", in_ready); end
    tick();
    rdata = 32'hDEADBEEF;
    #1;
    checks++; if (resp_pending !== 1'b0) begin errors++; $display("FAIL hold_pending got=%h exp=0", resp_pending); end
    tick();
    data_ok = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_out_valid got=%h exp=0", out_valid); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%h exp=1", in_ready); end
    checks++; if (result_bypass !== 32'h000080FF) begin errors++; $display("FAIL hold_bypass got=%h exp=000080ff", result_bypass); end
    tick();
    checks++; if (result_out !== 32'h000080FF) begin errors++; $display("FAIL hold_result got=%h exp=000080ff", result_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid_out got=%h exp=1", out_valid); end
    idle();
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; PC = 32'h1c000030; mem_op = 8'h04; alu_result = 32'h00003000;
    res_from_mem = 1'b1; gr_we = 1'b1; dest = 5'd9; req_issued = 1'b1;
    tick();
    pipe_flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (resp_pending !== 1'b1) begin errors++; $display("FAIL flush_pending got=%h exp=1", resp_pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%h exp=0", out_valid); end
    data_ok = 1'b1; rdata = 32'h0BAD0BAD;
    tick();
    data_ok = 1'b0;
    #1;
    checks++; if (resp_pending !== 1'b0) begin errors++; $display("FAIL flush_drained got=%h exp=0", resp_pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_discard_valid got=%h exp=0", out_valid); end
    in_valid = 1'b1; PC = 32'h1c000034; mem_op = 8'h04; alu_result = 32'h00003004;
    res_from_mem = 1'b1; gr_we = 1'b1; dest = 5'd10; req_issued = 1'b1;
    data_ok = 1'b1; rdata = 32'h11223344;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_next_ready got=%h exp=1", in_ready); end
    tick();
    checks++; if (result_out !== 32'h11223344) begin errors++; $display("FAIL flush_next_result got=%h exp=11223344", result_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got=%h exp=1", out_valid); end
    idle();
    tick();
  endtask

  task automatic test_saturate();
    in_valid = 1'b1; mem_op = 8'h04; res_from_mem = 1'b1; req_issued = 1'b1; pipe_flush = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1;
    checks++; if (resp_pending !== 1'b1) begin errors++; $display("FAIL sat_no_wrap got=%h exp=1", resp_pending); end
    data_ok = 1'b1;
    tick(); tick();
    checks++; if (resp_pending !== 1'b1) begin errors++; $display("FAIL sat_after_two got=%h exp=1", resp_pending); end
    tick();
    data_ok = 1'b0;
    #1;
    checks++; if (resp_pending !== 1'b0) begin errors++; $display("FAIL sat_drained got=%h exp=0", resp_pending); end
    tick();
  endtask

  task automatic test_early();
    in_valid = 1'b1; PC = 32'h1c000040; mem_op = 8'h04; alu_result = 32'h00004000;
    res_from_mem = 1'b1; gr_we = 1'b1; dest = 5'd3; req_issued = 1'b1;
    early_data_valid = 1'b1; early_data = 32'h12345678;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL early_ready got=%h exp=1", in_ready); end
    checks++; if (resp_pending !== 1'b0) begin errors++; $display("FAIL early_pending got=%h exp=0", resp_pending); end
    tick();
    checks++; if (result_out !== 32'h12345678) begin errors++; $display("FAIL early_result got=%h exp=12345678", result_out); end
    // Extension variants through the bypass path, no waiting needed.
    mem_op = 8'h02; alu_result = 32'h00004000; early_data = 32'h12348001;
    #1;
    checks++; if (result_bypass !== 32'hFFFF8001) begin errors++; $display("FAIL ext_ldh got=%h exp=ffff8001", result_bypass); end
    mem_op = 8'h08; alu_result = 32'h00004002; early_data = 32'h80FF1234;
    #1;
    checks++; if (result_bypass !== 32'h000000FF) begin errors++; $display("FAIL ext_ldbu got=%h exp=000000ff", result_bypass); end
    mem_op = 8'h01; alu_result = 32'h00004001;
    #1;
    checks++; if (result_bypass !== 32'h00000012) begin errors++; $display("FAIL ext_ldb_pos got=%h exp=00000012", result_bypass); end
    res_from_mem = 1'b0; res_from_side = 1'b1; side_result = 32'hCAFEF00D;
    #1;
    checks++; if (result_bypass !== 32'hCAFEF00D) begin errors++; $display("FAIL side_sel got=%h exp=cafef00d", result_bypass); end
    idle();
    tick();
  endtask

  task automatic test_exception();
    in_valid = 1'b1; PC = 32'h1c000050; mem_op = 8'h04; alu_result = 32'h00005001;
    gr_we = 1'b1; dest = 5'd4; req_issued = 1'b1; has_exception = 1'b1;
    exc_info = 47'h1A2B3C4D5E6F;
    #1;
    checks++; if (this_flush !== 1'b1) begin errors++; $display("FAIL exc_this_flush got=%h exp=1", this_flush); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL exc_ready got=%h exp=1", in_ready); end
    checks++; if (resp_pending !== 1'b0) begin errors++; $display("FAIL exc_pending got=%h exp=0", resp_pending); end
    tick();
    checks++; if (has_exception_out !== 1'b1) begin errors++; $display("FAIL exc_flag got=%h exp=1", has_exception_out); end
    checks++; if (exc_info_out !== 47'h1A2B3C4D5E6F) begin errors++; $display("FAIL exc_info got=%h exp=1a2b3c4d5e6f", exc_info_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL exc_out_valid got=%h exp=1", out_valid); end
    idle();
    wb_flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (this_flush !== 1'b1) begin errors++; $display("FAIL wbflush_this_flush got=%h exp=1", this_flush); end
    idle();
    tick();
  endtask

  task automatic test_store();
    in_valid = 1'b1; PC = 32'h1c000060; mem_op = 8'h80; alu_result = 32'h00006000;
    gr_we = 1'b0; dest = 5'd0; req_issued = 1'b1; data_ok = 1'b1; rdata = 32'h55555555;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_ready got=%h exp=1", in_ready); end
    tick();
    checks++; if (gr_we_out !== 1'b0) begin errors++; $display("FAIL st_gr_we got=%h exp=0", gr_we_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL st_out_valid got=%h exp=1", out_valid); end
    checks++; if (result_out !== 32'h00006000) begin errors++; $display("FAIL st_result got=%h exp=00006000", result_out); end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_hold();
    test_flush();
    test_saturate();
    test_early();
    test_exception();
    test_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
